// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator sequencer: ALU opcodes, FSM states
// and the layout of a queued command entry.
package alu_pkg;

  localparam int OP_W   = 3;
  localparam int CTRL_W = OP_W + 2;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_NOT = 3'd5;
  localparam logic [OP_W-1:0] OP_SHL = 3'd6;
  localparam logic [OP_W-1:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_OUT
  } state_t;

  // Control half of a FIFO entry; the operand is appended below it.
  typedef struct packed {
    logic            load;
    logic            last;
    logic [OP_W-1:0] op;
  } cmd_ctrl_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO, DEPTH x W, registered read head; zero-cycle flags.
// Pushes while full and pops while empty are ignored; no push-through.
module cmd_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Accumulator command sequencer feeding an external combinational ALU.
// One command per IDLE+EXEC pair; a result stalls the FSM until res_ready.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_op,
  input  logic [DW-1:0]   cmd_data,
  input  logic            cmd_load,
  input  logic            cmd_last,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [DW-1:0]   alu_y,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [DW-1:0]   res_data
);

  localparam int EW = CTRL_W + DW;

  state_t          state_q, state_d;
  logic [DW-1:0]   acc;
  logic [DW-1:0]   acc_next;
  cmd_ctrl_t       cur_ctrl;
  logic [DW-1:0]   cur_data;
  cmd_ctrl_t       head_ctrl;
  logic [DW-1:0]   head_data;
  cmd_ctrl_t       push_ctrl;
  logic [EW-1:0]   fifo_rd;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;

  assign push_ctrl = '{load: cmd_load, last: cmd_last, op: cmd_op};
  assign cmd_ready = !fifo_full && !rst;
  assign fifo_push = cmd_valid && cmd_ready;
  assign {head_ctrl, head_data} = fifo_rd;

  cmd_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({push_ctrl, cmd_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ALU drive is purely registered so it is deterministic in every state.
  assign alu_a    = acc;
  assign alu_b    = cur_data;
  assign alu_op   = cur_ctrl.op;
  assign acc_next = cur_ctrl.load ? cur_data : alu_y;

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = S_EXEC;
        end
      end
      S_EXEC:  state_d = cur_ctrl.last ? S_OUT : S_IDLE;
      S_OUT:   if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc       <= '0;
      cur_ctrl  <= '0;
      cur_data  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) begin
        cur_ctrl <= head_ctrl;
        cur_data <= head_data;
      end
      if (state_q == S_EXEC) begin
        acc <= acc_next;
        if (cur_ctrl.last) begin
          res_valid <= 1'b1;
          res_data  <= acc_next;
        end
      end
      if (state_q == S_OUT && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural ALU closing the loop.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic          cmd_load;
  logic          cmd_last;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_y;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_seq #(.DW(DW), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_load  (cmd_load),
    .cmd_last  (cmd_last),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_y     (alu_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  always_comb begin
    alu_y = '0;
    case (alu_op)
      OP_ADD: alu_y = alu_a + alu_b;
      OP_SUB: alu_y = alu_a - alu_b;
      OP_AND: alu_y = alu_a & alu_b;
      OP_OR:  alu_y = alu_a | alu_b;
      OP_XOR: alu_y = alu_a ^ alu_b;
      OP_NOT: alu_y = ~alu_a;
      OP_SHL: alu_y = alu_a << 1;
      OP_SHR: alu_y = alu_a >> 1;
      default: alu_y = '0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic load, input logic last, input logic [2:0] op,
                      input logic [DW-1:0] data);
    logic rdy;
    rdy       = 1'b0;
    cmd_load  = load;
    cmd_last  = last;
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rdy = cmd_ready;
      step();
      if (rdy) break;
    end
    cmd_valid = 1'b0;
    if (!rdy) check("send_accept", {31'd0, rdy}, 32'd1);
  endtask

  task automatic wait_result(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (res_valid) break;
      step();
    end
    check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
  endtask

  // Expects res_ready already high: result must last exactly one cycle.
  task automatic get_result(input string tag, input logic [DW-1:0] exp);
    wait_result(tag);
    check(tag, {24'd0, res_data}, {24'd0, exp});
    step();
    check({tag, "_pulse"}, {31'd0, res_valid}, 32'd0);
  endtask

  task automatic pair(input string tag, input logic [DW-1:0] ld, input logic [2:0] op,
                      input logic [DW-1:0] b, input logic [DW-1:0] exp);
    send(1'b1, 1'b0, OP_ADD, ld);
    send(1'b0, 1'b1, op, b);
    get_result(tag, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    cmd_load = 1'b0; cmd_last = 1'b0; res_ready = 1'b0;
    step();
    step();
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", {24'd0, res_data}, 32'd0);
    check("rst_alu_a", {24'd0, alu_a}, 32'd0);
    check("rst_alu_b", {24'd0, alu_b}, 32'd0);
    check("rst_alu_op", {29'd0, alu_op}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Basic function, one-cycle result pulse, wrap, acc retention.
    res_ready = 1'b1;
    pair("add", 8'h04, OP_ADD, 8'h07, 8'h0B);
    pair("sub_wrap", 8'h04, OP_SUB, 8'h07, 8'hFD);
    send(1'b0, 1'b1, OP_SHR, 8'h00);
    get_result("shr_retain", 8'h7E);
    pair("shl", 8'h81, OP_SHL, 8'h00, 8'h02);
    pair("not", 8'hF0, OP_NOT, 8'h00, 8'h0F);
    pair("xor", 8'h0C, OP_XOR, 8'h0A, 8'h06);
    pair("and", 8'hF0, OP_AND, 8'h3C, 8'h30);
    pair("or", 8'h50, OP_OR, 8'h0A, 8'h5A);

    // Backpressure: result held, four commands queue, fifth is refused.
    res_ready = 1'b0;
    send(1'b1, 1'b1, OP_ADD, 8'h01);
    for (int k = 0; k < 4; k++) send(1'b0, 1'b0, OP_ADD, 8'h01);
    check("bp_full", {31'd0, cmd_ready}, 32'd0);
    cmd_load = 1'b0; cmd_last = 1'b0; cmd_op = OP_ADD; cmd_data = 8'h01;
    cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("bp_ready_low", {31'd0, cmd_ready}, 32'd0);
      check("bp_res_valid", {31'd0, res_valid}, 32'd1);
      check("bp_res_data", {24'd0, res_data}, 32'h01);
      step();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    step();
    check("bp_release", {31'd0, res_valid}, 32'd0);
    send(1'b0, 1'b1, OP_ADD, 8'h00);
    get_result("bp_drain", 8'h05);

    // Push and pop on the same edge with three entries queued.
    res_ready = 1'b0;
    send(1'b1, 1'b1, OP_ADD, 8'h40);
    send(1'b0, 1'b0, OP_ADD, 8'h01);
    send(1'b0, 1'b0, OP_ADD, 8'h02);
    send(1'b0, 1'b0, OP_ADD, 8'h04);
    check("pp_three_ready", {31'd0, cmd_ready}, 32'd1);
    wait_result("pp_first");
    check("pp_first", {24'd0, res_data}, 32'h40);
    res_ready = 1'b1;
    step();
    check("pp_handshake", {31'd0, res_valid}, 32'd0);
    cmd_load = 1'b0; cmd_last = 1'b0; cmd_op = OP_ADD; cmd_data = 8'h08;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("pp_ready_1", {31'd0, cmd_ready}, 32'd1);
    check("pp_pop_1", {24'd0, alu_b}, 32'h01);
    step();
    cmd_last = 1'b1; cmd_data = 8'h10;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("pp_ready_2", {31'd0, cmd_ready}, 32'd1);
    check("pp_pop_2", {24'd0, alu_b}, 32'h02);
    get_result("pp_sum", 8'h5F);

    // Reset during EXEC with three commands still queued.
    res_ready = 1'b0;
    send(1'b1, 1'b1, OP_ADD, 8'h55);
    for (int k = 0; k < 4; k++) send(1'b0, 1'b0, OP_ADD, 8'h01);
    wait_result("mr_first");
    res_ready = 1'b1;
    step();
    step();
    check("mr_exec_a", {24'd0, alu_a}, 32'h55);
    check("mr_exec_b", {24'd0, alu_b}, 32'h01);
    rst = 1'b1;
    step();
    check("mr_res_valid", {31'd0, res_valid}, 32'd0);
    check("mr_alu_a", {24'd0, alu_a}, 32'd0);
    check("mr_alu_b", {24'd0, alu_b}, 32'd0);
    check("mr_ready_in_rst", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("mr_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("mr_no_pop", {24'd0, alu_b}, 32'd0);
    check("mr_acc_idle", {24'd0, alu_a}, 32'd0);
    check("mr_no_result", {31'd0, res_valid}, 32'd0);
    send(1'b1, 1'b1, OP_ADD, 8'h22);
    get_result("mr_after", 8'h22);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
